pipe_fetch: RTL and testbench
=============================

PIPE_FETCH -- requirements
Module: pipe_fetch

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 SHALL have port clr, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port pcsource, input, 2 bits: next-PC select from decode (00 seq, 01 branch, 10 jr, 11 jump).
REQ-004 SHALL have ports bpc, jpc, da, inputs, 32 bits each: branch target, jump target, jr register value from decode.
REQ-005 SHALL have port nostall, input, 1 bit: decode accepts the current IF/ID contents this cycle.
REQ-006 SHALL have ports imem_req (output, 1 bit) and imem_addr (output, 32 bits): instruction fetch request and word address.
REQ-007 SHALL have ports imem_ack (input, 1 bit) and imem_rdata (input, 32 bits): fetch response, data valid with ack.
REQ-008 SHALL have ports dinst, dpc4 (outputs, 32 bits) and dvalid (output, 1 bit): IF/ID register to decode.
REQ-009 SHALL have port pc, output, 32 bits: current fetch PC (debug/trace).

Function
REQ-010 SHALL implement FSM states FETCH (imem_req=1), FULL (imem_req=0, skid buffer occupied).
REQ-011 SHALL drive imem_addr=pc and hold pc stable while imem_req=1 and imem_ack=0.
REQ-012 SHALL define "accept" = dvalid & nostall and "room" = ~dvalid | nostall.
REQ-013 SHALL, in FETCH on imem_ack with room: load dinst<=imem_rdata, dpc4<=pc+4, dvalid<=1, stay FETCH.
REQ-014 SHALL, in FETCH on imem_ack without room: store rdata and pc+4 in skid, go FULL, no request next cycle.
REQ-015 SHALL, in FULL on nostall: move skid to IF/ID (dvalid<=1), return to FETCH with request next cycle.
REQ-016 SHALL, on accept with no new instruction delivered, set dvalid<=0 and dinst<=32'h0 (NOP bubble).
REQ-017 SHALL advance pc<=pc+4 (mod 2^32, wrap silently) on every imem_ack unless a redirect applies.
REQ-018 SHALL treat accept with pcsource!=00 as a redirect to T = {pc+4, bpc, da, jpc}[pcsource] after one delay slot.
REQ-019 SHALL apply redirect target to pc on the imem_ack of the delay slot if that ack is in the same cycle.
REQ-020 SHALL apply redirect immediately (pc<=T) if in FULL (delay slot already in skid).
REQ-021 SHALL otherwise latch T in redir_pc with redir_pend=1 and apply it at the next imem_ack, then clear redir_pend.
REQ-022 SHALL ignore pcsource when dvalid=0 or nostall=0.
REQ-023 SHALL never drop or duplicate an instruction: each acked word reaches dinst exactly once, in order.
REQ-024 SHALL accept imem_ack in the same cycle as imem_req rises (zero-wait memory) and any later cycle.
REQ-025 SHALL ignore imem_ack when imem_req=0.

Reset
REQ-026 SHALL, on clr=1, asynchronously set pc=0, dinst=0, dpc4=0, dvalid=0, skid empty, redir_pend=0, redir_pc=0, state FETCH.
REQ-027 SHALL drive imem_req=0 while clr=1 and assert it on the first clock edge after release.
REQ-028 SHALL, on reset mid-fetch, abandon the outstanding request; a late ack after reset is not treated as the response to the abandoned fetch.

Structure
REQ-029 SHALL take pcsource encodings (PCS_SEQ, PCS_BR, PCS_JR, PCS_J), NOP word and reset PC from the shared pipeline package.
REQ-030 SHALL instantiate one mux4x32 sub-module for next-PC selection; FSM, skid and redirect logic inline.

Verification
REQ-031 SHALL cover zero-wait stream: ack every cycle, nostall=1 -> imem_addr 0,4,8,12; dpc4 4,8,12 one cycle behind.
REQ-032 SHALL cover taken beq: branch at 0x8 accepted with pcsource=01, bpc=0x40 -> fetches 0xC (delay slot) then 0x40.
REQ-033 SHALL cover redirect before delay-slot ack: ack delayed 3 cycles, jr pcsource=10, da=0x100 -> addr 0x10 held, then 0x100.
REQ-034 SHALL cover stall: nostall=0 for 4 cycles while ack arrives -> FULL, imem_req=0, dinst unchanged, no instruction lost.
REQ-035 SHALL cover bubble: nostall=1, ack withheld -> dvalid=0, dinst=0 next cycle; pcsource ignored.
REQ-036 SHALL cover clr pulse mid-fetch at pc=0x20 -> all outputs zero immediately; first post-reset addr 0x0.

Source files
------------

// File: rtl/pipe_fetch_pkg.sv
// rtl/pipe_fetch_pkg.sv - shared pipeline constants for the fetch stage
package pipe_fetch_pkg;

   // next-PC select encodings driven by decode
   localparam logic [1:0] PCS_SEQ = 2'b00;
   localparam logic [1:0] PCS_BR  = 2'b01;
   localparam logic [1:0] PCS_JR  = 2'b10;
   localparam logic [1:0] PCS_J   = 2'b11;

   localparam logic [31:0] NOP_WORD = 32'h0000_0000;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef enum logic {
      ST_FETCH = 1'b0,
      ST_FULL  = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/pipe_fetch_mux4x32.sv
// rtl/pipe_fetch_mux4x32.sv - 4:1 32-bit mux indexed by pcsource encoding
module mux4x32
   import pipe_fetch_pkg::*;
(
   input  logic [1:0]  sel,
   input  logic [31:0] d0,
   input  logic [31:0] d1,
   input  logic [31:0] d2,
   input  logic [31:0] d3,
   output logic [31:0] y
);

   // select one of four candidate next-PC values
   always_comb begin
      y = d0;
      case (sel)
         PCS_BR:  y = d1;
         PCS_JR:  y = d2;
         PCS_J:   y = d3;
         default: y = d0;
      endcase
   end

endmodule

// File: rtl/pipe_fetch.sv
// rtl/pipe_fetch.sv - instruction fetch stage with skid buffer and delayed redirect
module pipe_fetch
   import pipe_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        clr,
   input  logic [1:0]  pcsource,
   input  logic [31:0] bpc,
   input  logic [31:0] jpc,
   input  logic [31:0] da,
   input  logic        nostall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] dinst,
   output logic [31:0] dpc4,
   output logic        dvalid,
   output logic [31:0] pc
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  dinst_q, dinst_d;
   logic [31:0]  dpc4_q, dpc4_d;
   logic         dvalid_q, dvalid_d;
   logic [31:0]  skid_inst_q, skid_inst_d;
   logic [31:0]  skid_pc4_q, skid_pc4_d;
   logic [31:0]  redir_pc_q, redir_pc_d;
   logic         redir_pend_q, redir_pend_d;
   // keeps the request low for the first cycle after reset so a stale ack is ignored
   logic         started_q, started_d;

   logic [31:0]  pc_plus4;
   logic [31:0]  redir_tgt;
   logic         ack_v;
   logic         accept;
   logic         room;
   logic         redir_now;

   assign pc_plus4  = pc_q + 32'd4;
   assign imem_req  = started_q & (state_q == ST_FETCH);
   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign dinst     = dinst_q;
   assign dpc4      = dpc4_q;
   assign dvalid    = dvalid_q;

   assign ack_v     = imem_ack & imem_req;
   assign accept    = dvalid_q & nostall;
   assign room      = ~dvalid_q | nostall;
   assign redir_now = accept & (pcsource != PCS_SEQ);

   mux4x32 u_next_pc_mux (
      .sel (pcsource),
      .d0  (pc_plus4),
      .d1  (bpc),
      .d2  (da),
      .d3  (jpc),
      .y   (redir_tgt)
   );

   // next-state: fetch handshake, IF/ID load or skid, bubbles and redirect timing
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      dinst_d      = dinst_q;
      dpc4_d       = dpc4_q;
      dvalid_d     = dvalid_q;
      skid_inst_d  = skid_inst_q;
      skid_pc4_d   = skid_pc4_q;
      redir_pc_d   = redir_pc_q;
      redir_pend_d = redir_pend_q;
      started_d    = 1'b1;

      case (state_q)
         ST_FETCH: begin
            if (ack_v) begin
               // this ack is the delay slot whenever a redirect is live
               if (redir_now) begin
                  pc_d = redir_tgt;
               end else if (redir_pend_q) begin
                  pc_d = redir_pc_q;
               end else begin
                  pc_d = pc_plus4;
               end
               redir_pend_d = 1'b0;
               if (room) begin
                  dinst_d  = imem_rdata;
                  dpc4_d   = pc_plus4;
                  dvalid_d = 1'b1;
               end else begin
                  skid_inst_d = imem_rdata;
                  skid_pc4_d  = pc_plus4;
                  state_d     = ST_FULL;
               end
            end else begin
               if (accept) begin
                  dinst_d  = NOP_WORD;
                  dvalid_d = 1'b0;
               end
               // delay slot still in flight: remember target until its ack
               if (redir_now) begin
                  redir_pc_d   = redir_tgt;
                  redir_pend_d = 1'b1;
               end
            end
         end
         ST_FULL: begin
            if (nostall) begin
               dinst_d  = skid_inst_q;
               dpc4_d   = skid_pc4_q;
               dvalid_d = 1'b1;
               state_d  = ST_FETCH;
               // delay slot is already in the skid, so the target applies now
               if (redir_now) begin
                  pc_d = redir_tgt;
               end
            end
         end
         default: state_d = ST_FETCH;
      endcase
   end

   // state registers with asynchronous clear
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q      <= ST_FETCH;
         pc_q         <= RESET_PC;
         dinst_q      <= NOP_WORD;
         dpc4_q       <= 32'h0;
         dvalid_q     <= 1'b0;
         skid_inst_q  <= 32'h0;
         skid_pc4_q   <= 32'h0;
         redir_pc_q   <= 32'h0;
         redir_pend_q <= 1'b0;
         started_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         dinst_q      <= dinst_d;
         dpc4_q       <= dpc4_d;
         dvalid_q     <= dvalid_d;
         skid_inst_q  <= skid_inst_d;
         skid_pc4_q   <= skid_pc4_d;
         redir_pc_q   <= redir_pc_d;
         redir_pend_q <= redir_pend_d;
         started_q    <= started_d;
      end
   end

endmodule

// File: tb/tb_pipe_fetch.sv
// tb/tb_pipe_fetch.sv - table-driven bench with instruction scoreboard for pipe_fetch
module tb_pipe_fetch;
   import pipe_fetch_pkg::*;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic [1:0]  pcsource = 2'b00;
   logic [31:0] bpc = 32'h0;
   logic [31:0] jpc = 32'h0;
   logic [31:0] da = 32'h0;
   logic        nostall = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] dinst;
   logic [31:0] dpc4;
   logic        dvalid;
   logic [31:0] pc;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        clr;
      logic        ack;
      logic        nst;
      logic [1:0]  pcs;
      logic [31:0] tgt;
      logic        ereq;
      logic [31:0] eaddr;
      logic        edv;
      logic [31:0] edpc4;
   } vec_t;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc4;
   } sb_t;

   vec_t tbl[33];
   sb_t  sb[$];

   pipe_fetch dut (
      .clk        (clk),
      .clr        (clr),
      .pcsource   (pcsource),
      .bpc        (bpc),
      .jpc        (jpc),
      .da         (da),
      .nostall    (nostall),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .dinst      (dinst),
      .dpc4       (dpc4),
      .dvalid     (dvalid),
      .pc         (pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0001;
   endfunction

   function automatic vec_t mk(input int c, input int a, input int n, input int p,
                               input logic [31:0] t, input int er, input logic [31:0] ea,
                               input int ed, input logic [31:0] ep);
      vec_t v;
      v.clr   = (c != 0);
      v.ack   = (a != 0);
      v.nst   = (n != 0);
      v.pcs   = p[1:0];
      v.tgt   = t;
      v.ereq  = (er != 0);
      v.eaddr = ea;
      v.edv   = (ed != 0);
      v.edpc4 = ep;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // one cycle: drive at negedge, sample just after, scoreboard the handshakes
   task automatic apply_row(input vec_t v, input string tag);
      sb_t e;
      @(negedge clk);
      clr      = v.clr;
      imem_ack = v.ack;
      nostall  = v.nst;
      pcsource = v.pcs;
      bpc      = (v.pcs == PCS_BR) ? v.tgt : 32'h0BAD_0B00;
      da       = (v.pcs == PCS_JR) ? v.tgt : 32'h0BAD_0D00;
      jpc      = (v.pcs == PCS_J)  ? v.tgt : 32'h0BAD_0300;
      #1;
      imem_rdata = mem_word(imem_addr);
      chk({tag, "_req"}, {31'h0, imem_req}, {31'h0, v.ereq});
      chk({tag, "_addr"}, imem_addr, v.eaddr);
      chk({tag, "_pc"}, pc, v.eaddr);
      chk({tag, "_dvalid"}, {31'h0, dvalid}, {31'h0, v.edv});
      if (v.edv) chk({tag, "_dpc4"}, dpc4, v.edpc4);
      else       chk({tag, "_dinst_nop"}, dinst, NOP_WORD);
      if (v.clr) begin
         sb.delete();
      end else begin
         if (dvalid && nostall) begin
            if (sb.size() == 0) begin
               chk({tag, "_sb_underflow"}, 32'd0, 32'd1);
            end else begin
               e = sb.pop_front();
               chk({tag, "_sb_inst"}, dinst, e.inst);
               chk({tag, "_sb_pc4"}, dpc4, e.pc4);
            end
         end
         if (imem_req && imem_ack) begin
            e.inst = mem_word(imem_addr);
            e.pc4  = imem_addr + 32'd4;
            sb.push_back(e);
         end
      end
   endtask

   initial begin
      // clr ack nst pcs tgt | req addr dvalid dpc4
      tbl[0]  = mk(1,0,0,0,32'h0,         0,32'h0,        0,32'h0);
      tbl[1]  = mk(0,1,1,0,32'h0,         0,32'h0,        0,32'h0);
      tbl[2]  = mk(0,1,1,0,32'h0,         1,32'h0,        0,32'h0);
      tbl[3]  = mk(0,1,1,0,32'h0,         1,32'h4,        1,32'h4);
      tbl[4]  = mk(0,1,1,0,32'h0,         1,32'h8,        1,32'h8);
      tbl[5]  = mk(0,1,1,1,32'h40,        1,32'hC,        1,32'hC);
      tbl[6]  = mk(0,1,1,0,32'h0,         1,32'h40,       1,32'h10);
      tbl[7]  = mk(0,1,1,0,32'h0,         1,32'h44,       1,32'h44);
      tbl[8]  = mk(1,0,0,0,32'h0,         0,32'h0,        0,32'h0);
      tbl[9]  = mk(0,1,1,0,32'h0,         0,32'h0,        0,32'h0);
      tbl[10] = mk(0,1,1,0,32'h0,         1,32'h0,        0,32'h0);
      tbl[11] = mk(0,1,1,0,32'h0,         1,32'h4,        1,32'h4);
      tbl[12] = mk(0,1,1,0,32'h0,         1,32'h8,        1,32'h8);
      tbl[13] = mk(0,1,1,0,32'h0,         1,32'hC,        1,32'hC);
      tbl[14] = mk(0,0,1,2,32'h100,       1,32'h10,       1,32'h10);
      tbl[15] = mk(0,0,1,3,32'h200,       1,32'h10,       0,32'h0);
      tbl[16] = mk(0,0,1,0,32'h0,         1,32'h10,       0,32'h0);
      tbl[17] = mk(0,1,1,0,32'h0,         1,32'h10,       0,32'h0);
      tbl[18] = mk(0,1,1,0,32'h0,         1,32'h100,      1,32'h14);
      tbl[19] = mk(0,1,0,0,32'h0,         1,32'h104,      1,32'h104);
      tbl[20] = mk(0,1,0,0,32'h0,         0,32'h108,      1,32'h104);
      tbl[21] = mk(0,1,0,0,32'h0,         0,32'h108,      1,32'h104);
      tbl[22] = mk(0,1,0,0,32'h0,         0,32'h108,      1,32'h104);
      tbl[23] = mk(0,1,1,1,32'h300,       0,32'h108,      1,32'h104);
      tbl[24] = mk(0,1,1,0,32'h0,         1,32'h300,      1,32'h108);
      tbl[25] = mk(0,0,1,0,32'h0,         1,32'h304,      1,32'h304);
      tbl[26] = mk(0,0,1,1,32'h500,       1,32'h304,      0,32'h0);
      tbl[27] = mk(0,1,1,0,32'h0,         1,32'h304,      0,32'h0);
      tbl[28] = mk(0,0,0,3,32'h600,       1,32'h308,      1,32'h308);
      tbl[29] = mk(0,1,1,0,32'h0,         1,32'h308,      1,32'h308);
      tbl[30] = mk(0,1,1,2,32'hFFFF_FFFC, 1,32'h30C,      1,32'h30C);
      tbl[31] = mk(0,1,1,0,32'h0,         1,32'hFFFF_FFFC,1,32'h310);
      tbl[32] = mk(0,0,0,0,32'h0,         1,32'h0,        1,32'h0);

      for (int i = 0; i < 33; i++) begin
         apply_row(tbl[i], $sformatf("row%0d", i));
      end

      // clear pulse while the fetch at 0x20 is outstanding, then a late ack
      apply_row(mk(1,0,0,0,32'h0, 0,32'h0, 0,32'h0), "rst_a");
      apply_row(mk(0,0,1,0,32'h0, 0,32'h0, 0,32'h0), "rst_b");
      for (int i = 0; i < 8; i++) begin
         apply_row(mk(0,1,1,0,32'h0, 1,32'(i*4), (i > 0) ? 1 : 0, 32'(i*4)),
                   $sformatf("run%0d", i));
      end
      apply_row(mk(0,0,0,0,32'h0, 1,32'h20, 1,32'h20), "hold20");
      apply_row(mk(1,1,0,0,32'h0, 0,32'h0,  0,32'h0),  "clr_mid");
      apply_row(mk(0,1,1,0,32'h0, 0,32'h0,  0,32'h0),  "late_ack");
      apply_row(mk(0,1,1,0,32'h0, 1,32'h0,  0,32'h0),  "first_req");
      apply_row(mk(0,0,0,0,32'h0, 1,32'h4,  1,32'h4),  "first_data");
      chk("first_data_inst", dinst, mem_word(32'h0));
      chk("sb_residue", 32'(sb.size()), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
